// File: rtl/interruption_scheduler_pkg.sv
// Shared definitions for the interruption scheduler: FSM state encoding,
// pending-flag bundle and the syscall constants the decoder uses for the
// injected SWI.
package interruption_scheduler_pkg;

  localparam int WD_WIDTH_DEF   = 16;
  localparam int WD_DEFAULT_DEF = 1024;

  // Injected instruction is SWI 0x48; the offset selects the OS entry.
  localparam logic [7:0] SYSCALL_ID   = 8'h48;
  localparam logic [1:0] SYSCALL_WD   = 2'd0;
  localparam logic [1:0] SYSCALL_USER = 2'd3;

  typedef enum logic [1:0] {
    ST_USER   = 2'd0,
    ST_INJECT = 2'd1,
    ST_KERNEL = 2'd2
  } sched_state_e;

  typedef struct packed {
    logic usr;
    logic wd;
  } pending_t;

endpackage

// File: rtl/interruption_scheduler_if.sv
// Core/decoder handshake seen by the interruption scheduler.
// master: the core side (drives boundaries, acks, kernel returns).
// slave:  the scheduler (drives the injection requests and in_kernel).
interface interruption_scheduler_if;

  logic instr_boundary;
  logic decode_ack;
  logic kernel_return;
  logic is_user_request;
  logic wd_interruption;
  logic in_kernel;

  modport master (
    output instr_boundary,
    output decode_ack,
    output kernel_return,
    input  is_user_request,
    input  wd_interruption,
    input  in_kernel
  );

  modport slave (
    input  instr_boundary,
    input  decode_ack,
    input  kernel_return,
    output is_user_request,
    output wd_interruption,
    output in_kernel
  );

endinterface

// File: rtl/interruption_scheduler_watchdog_timer.sv
// Watchdog quantum counter: counts down once per tick, sticks at zero, and
// reloads from load_value on request. expired pulses on the tick that takes
// the count from 1 to 0.
module watchdog_timer #(
  parameter int WIDTH   = 16,
  parameter int DEFAULT = 1024
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             tick,
  input  logic             reload,
  input  logic [WIDTH-1:0] load_value,
  output logic [WIDTH-1:0] count,
  output logic             expired
);

  logic [WIDTH-1:0] count_q;
  logic [WIDTH-1:0] count_d;

  // Next count: reload wins, otherwise decrement toward a sticky zero.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    count_d = count_q;
    if (reload) begin
      count_d = load_value;
    end else if (tick && (count_q != '0)) begin
      count_d = count_q - WIDTH'(1);
    end
  end

  // Count register, loaded with the default quantum at reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
      count_q <= WIDTH'(DEFAULT);
    end else begin
      count_q <= count_d;
    end
  end

  assign count   = count_q;
  assign expired = tick & ~reload & (count_q == WIDTH'(1));

endmodule

// File: rtl/interruption_scheduler.sv
// Interruption scheduler: decides when the core leaves user code for the OS.
// Latches user requests and watchdog expiry, injects one syscall request per
// instruction boundary (user before watchdog), holds it until the decoder
// acks, then waits in KERNEL for kernel_return.
// Optional feature macro: INTERRUPTION_STATS_EN adds saturating 16-bit
// counters wd_taken_cnt / usr_taken_cnt of served injections.
module interruption_scheduler
  import interruption_scheduler_pkg::*;
#(
  parameter int WD_WIDTH   = WD_WIDTH_DEF,
  parameter int WD_DEFAULT = WD_DEFAULT_DEF
) (
  input  logic                    clock,
  input  logic                    reset,
  interruption_scheduler_if.slave dec,
  input  logic                    user_raise,
  input  logic                    wd_enable,
  input  logic                    quantum_load,
  input  logic [WD_WIDTH-1:0]     quantum_value,
  output logic [WD_WIDTH-1:0]     wd_count
`ifdef INTERRUPTION_STATS_EN
  ,
  output logic [15:0]             wd_taken_cnt,
  output logic [15:0]             usr_taken_cnt
`endif
);

  sched_state_e        state_q, state_d;
  pending_t            pend_q, pend_d;
  logic                usr_out_q, usr_out_d;
  logic                wd_out_q, wd_out_d;
  logic                in_kernel_q, in_kernel_d;
  logic [WD_WIDTH-1:0] reload_q, reload_d;
  logic [WD_WIDTH-1:0] quantum_eff;
  logic                wd_tick;
  logic                wd_reload;
  logic                wd_expired;

`ifdef INTERRUPTION_STATS_EN
  logic [15:0] wd_taken_q, wd_taken_d;
  logic [15:0] usr_taken_q, usr_taken_d;
`endif

  // A zero quantum would never expire; treat it as one instruction.
  assign quantum_eff = (quantum_value == '0) ? WD_WIDTH'(1) : quantum_value;

  // Watchdog runs only on user-mode boundaries and reloads on the return edge.
  assign wd_tick   = (state_q == ST_USER) & dec.instr_boundary & wd_enable;
  assign wd_reload = (state_q == ST_KERNEL) & dec.kernel_return;

  watchdog_timer #(
    .WIDTH   (WD_WIDTH),
    .DEFAULT (WD_DEFAULT)
  ) u_watchdog (
    .clock      (clock),
    .reset      (reset),
    .tick       (wd_tick),
    .reload     (wd_reload),
    .load_value (reload_d),
    .count      (wd_count),
    .expired    (wd_expired)
  );

  // Next-state logic for the FSM, pending latches, reload value and stats.
  always_comb begin
    state_d     = state_q;
    pend_d.usr  = pend_q.usr | user_raise;
    pend_d.wd   = pend_q.wd | wd_expired;
    usr_out_d   = usr_out_q;
    wd_out_d    = wd_out_q;
    in_kernel_d = in_kernel_q;
    // Feeding reload_d to the timer lets a load on the return edge apply at once.
    reload_d    = quantum_load ? quantum_eff : reload_q;
`ifdef INTERRUPTION_STATS_EN
    wd_taken_d  = wd_taken_q;
    usr_taken_d = usr_taken_q;
`endif

    case (state_q)
      ST_USER: begin
        // Decision includes events arriving on this very boundary.
        if (dec.instr_boundary && (pend_d.usr || pend_d.wd)) begin
          state_d   = ST_INJECT;
          usr_out_d = pend_d.usr;
          wd_out_d  = ~pend_d.usr;
        end
      end

      ST_INJECT: begin
        if (dec.decode_ack) begin
          state_d     = ST_KERNEL;
          usr_out_d   = 1'b0;
          wd_out_d    = 1'b0;
          in_kernel_d = 1'b1;
          if (usr_out_q) begin
            // A raise on the ack cycle is a fresh request and stays latched.
            pend_d.usr = user_raise;
`ifdef INTERRUPTION_STATS_EN
            if (usr_taken_q != '1) usr_taken_d = usr_taken_q + 16'd1;
`endif
          end else begin
            pend_d.wd = 1'b0;
`ifdef INTERRUPTION_STATS_EN
            if (wd_taken_q != '1) wd_taken_d = wd_taken_q + 16'd1;
`endif
          end
        end
      end

      ST_KERNEL: begin
        if (dec.kernel_return) begin
          state_d     = ST_USER;
          in_kernel_d = 1'b0;
        end
      end

      default: begin
        state_d     = ST_USER;
        usr_out_d   = 1'b0;
        wd_out_d    = 1'b0;
        in_kernel_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset aborts any injection in flight.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= ST_USER;
      pend_q      <= '0;
      usr_out_q   <= 1'b0;
      wd_out_q    <= 1'b0;
      in_kernel_q <= 1'b0;
      reload_q    <= WD_WIDTH'(WD_DEFAULT);
`ifdef INTERRUPTION_STATS_EN
      wd_taken_q  <= '0;
      usr_taken_q <= '0;
`endif
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      usr_out_q   <= usr_out_d;
      wd_out_q    <= wd_out_d;
      in_kernel_q <= in_kernel_d;
      reload_q    <= reload_d;
`ifdef INTERRUPTION_STATS_EN
      wd_taken_q  <= wd_taken_d;
      usr_taken_q <= usr_taken_d;
`endif
    end
  end

  assign dec.is_user_request = usr_out_q;
  assign dec.wd_interruption = wd_out_q;
  assign dec.in_kernel       = in_kernel_q;

`ifdef INTERRUPTION_STATS_EN
  assign wd_taken_cnt  = wd_taken_q;
  assign usr_taken_cnt = usr_taken_q;
`endif

endmodule

// File: tb/tb_interruption_scheduler.sv
// Bench for interruption_scheduler: directed scenarios followed by random
// traffic, checked against a mode/counter reference model. Injections are
// scoreboarded: the model queues each expected injection, a monitor pops and
// compares when the DUT raises a request.
module tb_interruption_scheduler;

  localparam int M_USER   = 0;
  localparam int M_INJECT = 1;
  localparam int M_KERNEL = 2;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        user_raise;
  logic        wd_enable;
  logic        quantum_load;
  logic [15:0] quantum_value;
  logic [15:0] wd_count;
`ifdef INTERRUPTION_STATS_EN
  logic [15:0] wd_taken_cnt;
  logic [15:0] usr_taken_cnt;
`endif

  always #5 clock = ~clock;

  interruption_scheduler_if dec_if ();

  interruption_scheduler dut (
    .clock         (clock),
    .reset         (reset),
    .dec           (dec_if),
    .user_raise    (user_raise),
    .wd_enable     (wd_enable),
    .quantum_load  (quantum_load),
    .quantum_value (quantum_value),
    .wd_count      (wd_count)
`ifdef INTERRUPTION_STATS_EN
    ,
    .wd_taken_cnt  (wd_taken_cnt),
    .usr_taken_cnt (usr_taken_cnt)
`endif
  );

  typedef struct {
    bit is_usr;
    int count;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  // Reference model state
  int m_mode, m_count, m_reload, m_wd_taken, m_usr_taken;
  bit m_usr, m_wd, m_serving_usr;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_mode = M_USER;
    m_count = 1024;
    m_reload = 1024;
    m_usr = 0;
    m_wd = 0;
    m_serving_usr = 0;
    m_wd_taken = 0;
    m_usr_taken = 0;
    exp_q.delete();
  endtask

  // One clock edge of the scheduler's rules, applied to the inputs present at it.
  task automatic model_step(input bit ib, input bit ack, input bit kr, input bit ur,
                            input bit en, input bit ql, input int qv);
    int nr;
    nr = ql ? ((qv == 0) ? 1 : qv) : m_reload;
    if (ur) m_usr = 1;
    case (m_mode)
      M_USER: begin
        if (ib && en && m_count > 0) begin
          m_count--;
          if (m_count == 0) m_wd = 1;
        end
        if (ib && (m_usr || m_wd)) begin
          m_mode = M_INJECT;
          m_serving_usr = m_usr;
          exp_q.push_back('{m_usr, m_count});
        end
      end
      M_INJECT: begin
        if (ack) begin
          if (m_serving_usr) begin
            m_usr = ur;
            if (m_usr_taken < 65535) m_usr_taken++;
          end else begin
            m_wd = 0;
            if (m_wd_taken < 65535) m_wd_taken++;
          end
          m_mode = M_KERNEL;
        end
      end
      default: begin
        if (kr) begin
          m_count = nr;
          m_mode = M_USER;
        end
      end
    endcase
    m_reload = nr;
  endtask

  task automatic check_state();
    check("wd_count", int'(wd_count), m_count);
    check("in_kernel", int'(dec_if.in_kernel), int'(m_mode == M_KERNEL));
    check("is_user_request", int'(dec_if.is_user_request), int'(m_mode == M_INJECT && m_serving_usr));
    check("wd_interruption", int'(dec_if.wd_interruption), int'(m_mode == M_INJECT && !m_serving_usr));
  endtask

  // Apply inputs for one cycle, step the model at the edge, check at negedge.
  task automatic drive(input bit ib, input bit ack, input bit kr, input bit ur,
                       input bit en, input bit ql, input int qv);
    dec_if.instr_boundary = ib;
    dec_if.decode_ack     = ack;
    dec_if.kernel_return  = kr;
    user_raise            = ur;
    wd_enable             = en;
    quantum_load          = ql;
    quantum_value         = 16'(qv);
    @(posedge clock);
    model_step(ib, ack, kr, ur, en, ql, qv);
    @(negedge clock);
    check_state();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 1, 0, 0);
  endtask

  task automatic boundary();
    drive(1, 0, 0, 0, 1, 0, 0);
  endtask

  // Monitor: every new injection request must match the head of the scoreboard.
  bit prev_req = 0;
  always @(negedge clock) begin
    exp_t e;
    bit   cur;
    check("exclusive_outputs", int'(dec_if.is_user_request & dec_if.wd_interruption), 0);
    cur = dec_if.is_user_request | dec_if.wd_interruption;
    if (!reset) begin
      prev_req = 0;
    end else begin
      if (cur && !prev_req) begin
        check("inject_expected", int'(exp_q.size() > 0), 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          check("inject_kind_usr", int'(dec_if.is_user_request), int'(e.is_usr));
          check("inject_wd_count", int'(wd_count), e.count);
        end
      end
      prev_req = cur;
    end
  end

  initial begin
    dec_if.instr_boundary = 0;
    dec_if.decode_ack     = 0;
    dec_if.kernel_return  = 0;
    user_raise    = 0;
    wd_enable     = 0;
    quantum_load  = 0;
    quantum_value = 0;
    model_reset();
    repeat (2) @(negedge clock);
    check_state();
    #1 reset = 1'b1;
    idle(2);

    // User raise in USER, served on the next boundary; count untouched (wd off).
    drive(0, 0, 0, 1, 1, 0, 0);
    drive(1, 0, 0, 0, 0, 0, 0);
    idle(2);
    drive(0, 1, 0, 0, 1, 0, 0);
    idle(1);
    // Return with a simultaneous quantum load of 3.
    drive(0, 0, 1, 0, 1, 1, 3);

    // Three boundaries expire the quantum; wd request follows the third.
    boundary(); idle(1); boundary(); idle(1); boundary();
    idle(1);
    drive(0, 1, 0, 0, 1, 0, 0);

    // Raise during KERNEL; boundaries and stray acks are ignored there.
    drive(0, 0, 0, 1, 1, 0, 0);
    for (int i = 0; i < 10; i++) boundary();
    drive(0, 1, 0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 1, 1, 2);
    boundary();
    drive(0, 1, 0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 1, 0, 0);

    // Expiry and user raise on the same boundary: user first, wd stays pending.
    boundary();
    drive(1, 0, 0, 1, 1, 0, 0);
    idle(1);
    drive(0, 1, 0, 0, 1, 0, 0);
    drive(0, 0, 1, 0, 1, 0, 0);
    boundary();
    drive(0, 1, 0, 0, 1, 0, 0);

    // Zero quantum loaded on return acts as one; one boundary expires it.
    drive(0, 0, 1, 0, 1, 1, 0);
    boundary();
    idle(1);

    // Kernel return outside KERNEL does nothing.
    drive(0, 0, 1, 0, 1, 0, 0);

    // Reset while wd_interruption is high: outputs drop immediately.
    check("pre_reset_wd_req", int'(dec_if.wd_interruption), 1);
    reset = 1'b0;
    #1;
    check("rst_usr_out", int'(dec_if.is_user_request), 0);
    check("rst_wd_out", int'(dec_if.wd_interruption), 0);
    check("rst_in_kernel", int'(dec_if.in_kernel), 0);
    model_reset();
    @(posedge clock);
    @(negedge clock);
    #1 reset = 1'b1;
    check_state();
    idle(1);

    // Random traffic.
    for (int n = 0; n < 4000; n++) begin
      bit ib, ack, kr, ur, en, ql;
      int qv;
      ib  = ($urandom_range(0, 2) == 0);
      ur  = ($urandom_range(0, 19) == 0);
      en  = ($urandom_range(0, 9) != 0);
      ack = (m_mode == M_INJECT) ? ($urandom_range(0, 2) == 0) : ($urandom_range(0, 29) == 0);
      kr  = (m_mode == M_KERNEL) ? ($urandom_range(0, 4) == 0) : ($urandom_range(0, 29) == 0);
      ql  = ($urandom_range(0, 9) == 0);
      qv  = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 6));
      drive(ib, ack, kr, ur, en, ql, qv);
    end
    drive(0, 0, 0, 0, 1, 0, 0);
    idle(3);

    check("scoreboard_drained", exp_q.size(), 0);
`ifdef INTERRUPTION_STATS_EN
    check("wd_taken_cnt", int'(wd_taken_cnt), m_wd_taken);
    check("usr_taken_cnt", int'(usr_taken_cnt), m_usr_taken);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
